// File: rtl/dac_ramp_sequencer.sv
// Stepped DAC ramp sequencer: writes a start code, then one saturating step per
// trigger rising edge through a req/ack handshake, with optional ramp repeat.
module dac_ramp_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dac_start_i,
  input  logic              trigger_i,
  input  logic [DATA_W-1:0] start_code_i,
  input  logic [DATA_W-1:0] step_size_i,
  input  logic              dir_down_i,
  input  logic [CNT_W-1:0]  num_steps_i,
  input  logic              repeat_i,
  input  logic              dac_wr_ack_i,
  output logic              dac_wr_req_o,
  output logic [DATA_W-1:0] dac_code_o,
  output logic [CNT_W-1:0]  step_index_o,
  output logic              busy_o,
  output logic              sweep_done_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_TRIG = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              trig_d_q;
  logic [DATA_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              ovr_q, ovr_d;

  logic [DATA_W-1:0] cfg_start_q, cfg_start_d;
  logic [DATA_W-1:0] cfg_step_q, cfg_step_d;
  logic              cfg_down_q, cfg_down_d;
  logic [CNT_W-1:0]  cfg_last_q, cfg_last_d;
  logic              cfg_rpt_q, cfg_rpt_d;

  logic              trig_edge;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W-1:0] next_code;

  assign trig_edge = trigger_i & ~trig_d_q;

  // The extra top bit of sum/diff is the carry/borrow that triggers saturation.
  always_comb begin
    sum_w  = {1'b0, code_q} + {1'b0, cfg_step_q};
    diff_w = {1'b0, code_q} - {1'b0, cfg_step_q};
    if (cfg_down_q) begin
      next_code = diff_w[DATA_W] ? '0 : diff_w[DATA_W-1:0];
    end else begin
      next_code = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    idx_d       = idx_q;
    ovr_d       = ovr_q;
    cfg_start_d = cfg_start_q;
    cfg_step_d  = cfg_step_q;
    cfg_down_d  = cfg_down_q;
    cfg_last_d  = cfg_last_q;
    cfg_rpt_d   = cfg_rpt_q;

    if (!dac_start_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cfg_start_d = start_code_i;
          cfg_step_d  = step_size_i;
          cfg_down_d  = dir_down_i;
          cfg_last_d  = (num_steps_i == '0) ? '0 : num_steps_i - CNT_W'(1);
          cfg_rpt_d   = repeat_i;
          code_d      = start_code_i;
          idx_d       = '0;
          ovr_d       = 1'b0;
          state_d     = REQ;
        end
        REQ: begin
          if (trig_edge) ovr_d = 1'b1;
          if (dac_wr_ack_i) state_d = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig_edge) begin
            if (idx_q == cfg_last_q) begin
              if (cfg_rpt_q) begin
                idx_d   = '0;
                code_d  = cfg_start_q;
                state_d = REQ;
              end else begin
                state_d = DONE;
              end
            end else begin
              idx_d   = idx_q + CNT_W'(1);
              code_d  = next_code;
              state_d = REQ;
            end
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      trig_d_q    <= 1'b0;
      code_q      <= '0;
      idx_q       <= '0;
      ovr_q       <= 1'b0;
      cfg_start_q <= '0;
      cfg_step_q  <= '0;
      cfg_down_q  <= 1'b0;
      cfg_last_q  <= '0;
      cfg_rpt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_d_q    <= trigger_i;
      code_q      <= code_d;
      idx_q       <= idx_d;
      ovr_q       <= ovr_d;
      cfg_start_q <= cfg_start_d;
      cfg_step_q  <= cfg_step_d;
      cfg_down_q  <= cfg_down_d;
      cfg_last_q  <= cfg_last_d;
      cfg_rpt_q   <= cfg_rpt_d;
    end
  end

  assign dac_wr_req_o = (state_q == REQ);
  assign dac_code_o   = code_q;
  assign step_index_o = idx_q;
  assign busy_o       = (state_q != IDLE);
  assign sweep_done_o = (state_q == DONE);
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Self-checking bench for dac_ramp_sequencer: expected DAC codes are queued by a
// reference model and compared when the DUT completes each write handshake.
module tb_dac_ramp_sequencer;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 16;
  localparam int unsigned MAXC = 65535;

  logic          clk = 1'b0;
  logic          reset;
  logic          dac_start;
  logic          trigger;
  logic [DW-1:0] start_code;
  logic [DW-1:0] step_size;
  logic          dir_down;
  logic [CW-1:0] num_steps;
  logic          rpt;
  logic          dac_wr_ack;
  logic          dac_wr_req;
  logic [DW-1:0] dac_code;
  logic [CW-1:0] step_index;
  logic          busy;
  logic          sweep_done;
  logic          overrun;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   wr_cnt   = 0;
  logic [DW-1:0] exp_q[$];
  bit            auto_ack  = 1'b1;
  bit            force_ack = 1'b0;
  int unsigned   req_age   = 0;

  dac_ramp_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .dac_start_i  (dac_start),
    .trigger_i    (trigger),
    .start_code_i (start_code),
    .step_size_i  (step_size),
    .dir_down_i   (dir_down),
    .num_steps_i  (num_steps),
    .repeat_i     (rpt),
    .dac_wr_ack_i (dac_wr_ack),
    .dac_wr_req_o (dac_wr_req),
    .dac_code_o   (dac_code),
    .step_index_o (step_index),
    .busy_o       (busy),
    .sweep_done_o (sweep_done),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned mdl_next(input int unsigned c, input int unsigned s, input bit dn);
    if (dn) return (s > c) ? 0 : c - s;
    return (c + s > MAXC) ? MAXC : c + s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writer model: acks the second cycle a request is seen, or follows force_ack.
  initial begin
    dac_wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (dac_wr_req && auto_ack) begin
        req_age++;
        dac_wr_ack = (req_age >= 2);
      end else begin
        req_age    = 0;
        dac_wr_ack = force_ack;
      end
    end
  end

  // Scoreboard: every accepted write must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && dac_start && dac_wr_req && dac_wr_ack) begin
        if (exp_q.size() == 0) check_eq("write_expected", exp_q.size(), 1);
        else check_eq("wr_code", {16'h0, dac_code}, {16'h0, exp_q.pop_front()});
        wr_cnt++;
      end
    end
  end

  task automatic wait_writes(input int unsigned target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (wr_cnt == target && !dac_wr_req) ok = 1'b1;
      else tick();
    end
    check_eq("wr_wait", ok, 1);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic run_ramp(input logic [DW-1:0] sc, input logic [DW-1:0] ss, input bit dn,
                          input logic [CW-1:0] ns, input bit rp, input int ntrig);
    int unsigned code, idx, last, target;
    bit done;
    last   = (ns == 0) ? 0 : ns - 1;
    code   = sc;
    idx    = 0;
    done   = 1'b0;
    start_code = sc; step_size = ss; dir_down = dn; num_steps = ns; rpt = rp;
    dac_start  = 1'b1;
    exp_q.push_back(sc);
    target = wr_cnt + 1;
    tick();
    check_eq("start_req", dac_wr_req, 1);
    check_eq("start_code", dac_code, sc);
    check_eq("start_idx", step_index, 0);
    check_eq("start_busy", busy, 1);
    check_eq("start_ovr", overrun, 0);
    wait_writes(target);
    for (int t = 0; t < ntrig; t++) begin
      if (idx == last) begin
        if (rp) begin idx = 0; code = sc; end
        else done = 1'b1;
      end else begin
        idx++;
        code = mdl_next(code, ss, dn);
      end
      if (!done) exp_q.push_back(code[DW-1:0]);
      tick();
      pulse_trigger();
      if (!done) begin
        check_eq("trig_req", dac_wr_req, 1);
        check_eq("trig_code", dac_code, code);
        check_eq("trig_idx", step_index, idx);
        target++;
        wait_writes(target);
      end else begin
        check_eq("done_flag", sweep_done, 1);
        check_eq("done_req", dac_wr_req, 0);
      end
    end
    check_eq("q_drained", exp_q.size(), 0);
    check_eq("sweep_done_end", sweep_done, done);
    dac_start = 1'b0;
    tick();
    check_eq("stop_busy", busy, 0);
    check_eq("stop_done", sweep_done, 0);
    check_eq("stop_req", dac_wr_req, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"}, dac_wr_req, 0);
    check_eq({tag, "_code"}, dac_code, 0);
    check_eq({tag, "_idx"}, step_index, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, sweep_done, 0);
    check_eq({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned target;
    reset = 1'b0; dac_start = 1'b0; trigger = 1'b0;
    start_code = '0; step_size = '0; dir_down = 1'b0; num_steps = '0; rpt = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();

    run_ramp(16'h1000, 16'h0100, 1'b0, 16'd4, 1'b0, 4);
    run_ramp(16'hFF00, 16'h0080, 1'b0, 16'd4, 1'b0, 4);
    run_ramp(16'h0100, 16'h0200, 1'b1, 16'd2, 1'b0, 2);
    run_ramp(16'h0800, 16'h0040, 1'b0, 16'd2, 1'b1, 5);
    run_ramp(16'h0555, 16'h0010, 1'b0, 16'd0, 1'b0, 1);

    // Overrun: trigger while the first write is still unacknowledged.
    auto_ack = 1'b0;
    start_code = 16'h2000; step_size = 16'h0010; dir_down = 1'b0; num_steps = 16'd4; rpt = 1'b0;
    dac_start = 1'b1;
    exp_q.push_back(16'h2000);
    tick();
    check_eq("ovr_req", dac_wr_req, 1);
    tick();
    pulse_trigger();
    check_eq("ovr_set", overrun, 1);
    check_eq("ovr_code", dac_code, 16'h2000);
    check_eq("ovr_idx", step_index, 0);
    check_eq("ovr_req_held", dac_wr_req, 1);
    auto_ack = 1'b1;
    target = wr_cnt + 1;
    wait_writes(target);
    exp_q.push_back(16'h2010);
    tick();
    pulse_trigger();
    check_eq("ovr_next_code", dac_code, 16'h2010);
    check_eq("ovr_next_idx", step_index, 1);
    target++;
    wait_writes(target);
    check_eq("ovr_sticky", overrun, 1);
    dac_start = 1'b0;
    tick();
    check_eq("ovr_idle_sticky", overrun, 1);
    check_eq("ovr_idle_busy", busy, 0);
    check_eq("ovr_q_drained", exp_q.size(), 0);

    // Abort with a coincident ack, then a late ack, then restart.
    auto_ack = 1'b0;
    start_code = 16'h3000; step_size = 16'h0001; num_steps = 16'd2;
    dac_start = 1'b1;
    tick();
    check_eq("abort_req_on", dac_wr_req, 1);
    dac_start = 1'b0;
    force_ack = 1'b1;
    tick();
    check_eq("abort_req", dac_wr_req, 0);
    check_eq("abort_busy", busy, 0);
    tick();
    check_eq("late_ack_req", dac_wr_req, 0);
    check_eq("late_ack_busy", busy, 0);
    force_ack = 1'b0;
    auto_ack  = 1'b1;
    run_ramp(16'h3000, 16'h0001, 1'b0, 16'd2, 1'b0, 2);

    // Reset in the middle of a pending request with overrun set.
    auto_ack = 1'b0;
    start_code = 16'h4000; step_size = 16'h0100; num_steps = 16'd4;
    dac_start = 1'b1;
    tick();
    tick();
    pulse_trigger();
    check_eq("rst_pre_ovr", overrun, 1);
    reset = 1'b0;
    dac_start = 1'b0;
    tick();
    check_reset_vals("midrst");
    reset = 1'b1;
    tick();
    check_eq("post_rst_req", dac_wr_req, 0);
    check_eq("post_rst_busy", busy, 0);
    auto_ack = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
